serial_adder: RTL and testbench

- Bit-serial N-bit adder built around the existing single-bit full_adder cell (ports x, y, z, sumf, carryf), instantiated once.
- Takes two WIDTH-bit operands and a carry-in on a start pulse, then feeds them LSB-first through the full_adder, one bit per clock.
- A carry flip-flop closes the loop and a shift register collects the result.
- Sits directly around the full_adder: it supplies the cell's x/y/z inputs and consumes its sumf/carryf each cycle. It is the area-minimal alternative to a ripple chain.

---
 rtl/serial_adder.sv | 172 +++++++++++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder -- bit-serial WIDTH-bit adder built around one full_adder cell.
//
// Operands are captured on an accepted start pulse and fed LSB-first through
// a single full_adder, one bit per clock. A carry flop closes the loop and a
// shift register collects the sum bits, which are published on entry to DONE.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input. With
// sub=1 the adder computes a - b (B inverted, carry-in forced to 1) and cout=1
// means no borrow.
//
// Handshake: start is only sampled in IDLE; it is ignored (not queued) while
// busy or done is high. done is a one-cycle pulse during which sum/cout are
// valid; sum/cout then hold until the next operation completes or rst.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   start       in   request pulse, sampled in IDLE only
//   a, b        in   WIDTH-bit operands, captured on accepted start
//   cin         in   carry-in, captured on accepted start
//   sub         in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy        out  high while bits are being processed (RUN)
//   done        out  one-cycle pulse, sum/cout valid (DONE)
//   sum         out  WIDTH-bit result
//   cout        out  final carry
//   o_dbg_state out  FSM state: 0=IDLE, 1=RUN, 2=DONE
// ---------------------------------------------------------------------------

module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic sumf,
   output logic carryf
);
   assign sumf   = x ^ y ^ z;
   assign carryf = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_sumf;
   logic               w_carryf;
   logic               w_last;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_c_load;

   // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   full_adder u_fa (
      .x      (r_a_sh[0]),
      .y      (r_b_sh[0]),
      .z      (r_carry),
      .sumf   (w_sumf),
      .carryf (w_carryf)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode, purely from registered state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
               end
            end
            ST_RUN: begin
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_sum_sh <= {w_sumf, r_sum_sh[WIDTH-1:1]};
               r_carry  <= w_carryf;
               r_cnt    <= r_cnt + CNT_W'(1);
               // Publish on the final bit so partial sums never appear on sum.
               if (w_last) begin
                  r_sum  <= {w_sumf, r_sum_sh[WIDTH-1:1]};
                  r_cout <= w_carryf;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum         = r_sum;
   assign cout        = r_cout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // Result computed with plain arithmetic on acceptance; timing tracked as
  // "cycles left in the operation".
  logic [W:0]   m_res;
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic [W:0]   exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_res  = exp_q.pop_front();
        m_sum  = m_res[W-1:0];
        m_cout = m_res[W];
        m_done = 1'b1;
      end
    end else if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) exp_q.push_back({1'b0, a} + {1'b0, ~b} + (W+1)'(1));
      else     exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
`else
      exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
`endif
      m_left = W;
    end
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", (W+1)'(busy), (W+1)'(m_left > 0));
      check("done", (W+1)'(done), (W+1)'(m_done));
      check("sum",  (W+1)'(sum),  (W+1)'(m_sum));
      check("cout", (W+1)'(cout), (W+1)'(m_cout));
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub ignored in add-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom_range(0, 255); b = $urandom_range(0, 255); cin = 1'($urandom_range(0, 1));
  endtask

  // Waits for done (bounded); returns negedges waited, or -1 on timeout.
  task automatic wait_done(output int waited);
    waited = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) check("done_timeout", 0, 1);
  endtask

  task automatic op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tc, input logic ts,
                    input logic [W-1:0] exp_sum, input logic exp_cout);
    int w;
    pulse_start(ta, tb, tc, ts);
    wait_done(w);
    check({name, "_sum"},  (W+1)'(sum),  (W+1)'(exp_sum));
    check({name, "_cout"}, (W+1)'(cout), (W+1)'(exp_cout));
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_sum",   (W+1)'(sum),       '0);
    check("reset_state", (W+1)'(dbg_state), '0);

    // Basic add with latency check: done on the 8th negedge after the
    // cycle following acceptance.
    pulse_start(8'h35, 8'h1A, 1'b0, 1'b0);
    wait_done(w);
    check("basic_latency", (W+1)'(w), (W+1)'(W));
    check("basic_sum",  (W+1)'(sum),  (W+1)'(8'h4F));
    check("basic_cout", (W+1)'(cout), '0);
    @(negedge clk);

    op("wrap1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    op("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    op("mid",   8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);
    op("carry", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

    // Start during busy is ignored.
    d0 = done_cnt;
    pulse_start(8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(w);
    check("ignore_sum",  (W+1)'(sum),  (W+1)'(8'h02));
    check("ignore_cout", (W+1)'(cout), '0);
    repeat (12) @(negedge clk);
    check("ignore_one_done", (W+1)'(done_cnt - d0), (W+1)'(1));

    // Reset mid-operation: no done, everything cleared.
    d0 = done_cnt;
    pulse_start(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_done", (W+1)'(done_cnt - d0), '0);
    check("rst_sum",   (W+1)'(sum),       '0);
    check("rst_state", (W+1)'(dbg_state), '0);
    op("after_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

    // start held high: one op per W+2 cycles, two done pulses in 20 cycles.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    check("held_two_done", (W+1)'(done_cnt - d0), (W+1)'(2));
    check("held_sum", (W+1)'(sum), (W+1)'(8'h07));
    repeat (12) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    op("sub2", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    op("sub0", 8'h35, 8'h1A, 1'b1, 1'b0, 8'h50, 1'b0);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
